// File: rtl/dmi_bridge_pkg.sv
// Shared types for the DMI-to-register-bus bridge: request opcodes,
// response codes, bridge states and the DMI request/response records.
package dmi_bridge_pkg;

  localparam int unsigned DMI_ADDR_W = 7;
  localparam int unsigned DMI_DATA_W = 32;
  // Wide enough for the largest legal timeout (65535).
  localparam int unsigned TMO_CNT_W  = 16;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    SUCCESS = 2'd0,
    FAILED  = 2'd2
  } dmi_resp_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } bridge_state_e;

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    dmi_op_e               op;
    logic [DMI_DATA_W-1:0] data;
  } dmi_req_t;

  typedef struct packed {
    dmi_resp_e             resp;
    logic [DMI_DATA_W-1:0] data;
  } dmi_resp_t;

  // Map a register-bus error flag onto the DMI response code.
  function automatic dmi_resp_e completion_code(input logic err);
    return err ? FAILED : SUCCESS;
  endfunction

endpackage

// File: rtl/dmi_reg_bridge.sv
// DMI request/response channel to single-outstanding valid/grant register
// bus bridge. A timeout turns a stalled register access into a failed
// DMI response. Every output comes straight from a flop.
module dmi_reg_bridge
  import dmi_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = DMI_ADDR_W,
  parameter int unsigned DATA_W  = DMI_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmi_req_valid,
  output logic              dmi_req_ready,
  input  logic [ADDR_W-1:0] dmi_req_addr,
  input  logic [1:0]        dmi_req_op,
  input  logic [DATA_W-1:0] dmi_req_data,
  output logic              dmi_resp_valid,
  input  logic              dmi_resp_ready,
  output logic [1:0]        dmi_resp_resp,
  output logic [DATA_W-1:0] dmi_resp_data,
  output logic              reg_req,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic              reg_gnt,
  input  logic              reg_rvalid,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_err
);

  // Counter value on the last cycle an access may still complete normally.
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

  bridge_state_e          state_r;
  bridge_state_e          state_s;
  dmi_op_e                op_r;
  dmi_op_e                req_op_s;
  logic [TMO_CNT_W-1:0]   tmo_cnt_r;
  logic                   timeout_s;
  logic                   accept_s;
  logic                   req_ready_r;
  logic                   resp_valid_r;
  logic                   reg_req_r;
  logic                   reg_we_r;
  logic [ADDR_W-1:0]      reg_addr_r;
  logic [DATA_W-1:0]      reg_wdata_r;
  dmi_resp_e              resp_r;
  dmi_resp_e              resp_s;
  logic [DATA_W-1:0]      resp_data_r;
  logic [DATA_W-1:0]      resp_data_s;
  logic [DATA_W-1:0]      done_data_s;

  assign req_op_s    = dmi_op_e'(dmi_req_op);
  // req_ready_r is only ever high while the state register holds IDLE.
  assign accept_s    = dmi_req_valid && req_ready_r;
  assign timeout_s   = (tmo_cnt_r == TMO_LAST);
  assign done_data_s = (op_r == READ && !reg_err) ? reg_rdata : {DATA_W{1'b0}};

  // Next state and next response contents; the response only changes on entry to RESP.
  always_comb begin
    state_s     = state_r;
    resp_s      = resp_r;
    resp_data_s = resp_data_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (req_op_s)
            NOP: begin
              state_s     = RESP;
              resp_s      = SUCCESS;
              resp_data_s = {DATA_W{1'b0}};
            end
            READ, WRITE: begin
              state_s = ISSUE;
            end
            default: begin
              state_s     = RESP;
              resp_s      = FAILED;
              resp_data_s = {DATA_W{1'b0}};
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // Completion beats a timeout landing on the same cycle.
        if (reg_gnt && reg_rvalid) begin
          state_s     = RESP;
          resp_s      = completion_code(reg_err);
          resp_data_s = done_data_s;
        end else if (timeout_s) begin
          state_s     = RESP;
          resp_s      = FAILED;
          resp_data_s = {DATA_W{1'b0}};
        end else if (reg_gnt) begin
          state_s = WAIT;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT: begin
        if (reg_rvalid) begin
          state_s     = RESP;
          resp_s      = completion_code(reg_err);
          resp_data_s = done_data_s;
        end else if (timeout_s) begin
          state_s     = RESP;
          resp_s      = FAILED;
          resp_data_s = {DATA_W{1'b0}};
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        if (dmi_resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and state-decoded output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      reg_req_r    <= 1'b0;
      resp_r       <= SUCCESS;
      resp_data_r  <= {DATA_W{1'b0}};
    end else begin
      state_r      <= state_s;
      req_ready_r  <= (state_s == IDLE);
      resp_valid_r <= (state_s == RESP);
      reg_req_r    <= (state_s == ISSUE);
      resp_r       <= resp_s;
      resp_data_r  <= resp_data_s;
    end
  end

  // Latch the accepted register access and run the ISSUE/WAIT timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r        <= NOP;
      reg_we_r    <= 1'b0;
      reg_addr_r  <= {ADDR_W{1'b0}};
      reg_wdata_r <= {DATA_W{1'b0}};
      tmo_cnt_r   <= {TMO_CNT_W{1'b0}};
    end else if (state_r == IDLE && state_s == ISSUE) begin
      op_r        <= req_op_s;
      reg_we_r    <= (req_op_s == WRITE);
      reg_addr_r  <= dmi_req_addr;
      reg_wdata_r <= dmi_req_data;
      tmo_cnt_r   <= {TMO_CNT_W{1'b0}};
    end else if (state_r == ISSUE || state_r == WAIT) begin
      tmo_cnt_r   <= tmo_cnt_r + {{(TMO_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_r   <= tmo_cnt_r;
    end
  end

  assign dmi_req_ready  = req_ready_r;
  assign dmi_resp_valid = resp_valid_r;
  assign dmi_resp_resp  = resp_r;
  assign dmi_resp_data  = resp_data_r;
  assign reg_req        = reg_req_r;
  assign reg_we         = reg_we_r;
  assign reg_addr       = reg_addr_r;
  assign reg_wdata      = reg_wdata_r;

endmodule

// File: tb/tb_dmi_reg_bridge.sv
// Self-checking bench for dmi_reg_bridge (TIMEOUT = 8): a vector table of
// DMI transactions with scripted register-bus timing, a response scoreboard,
// and hand-written sequences for reset, backpressure and late completions.
module tb_dmi_reg_bridge;

  localparam int OP_NOP = 0, OP_READ = 1, OP_WRITE = 2, OP_RSVD = 3;
  localparam int RS_OK = 0, RS_FAIL = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dmi_req_valid = 1'b0;
  logic        dmi_req_ready;
  logic [6:0]  dmi_req_addr = 7'd0;
  logic [1:0]  dmi_req_op = 2'd0;
  logic [31:0] dmi_req_data = 32'd0;
  logic        dmi_resp_valid;
  logic        dmi_resp_ready = 1'b1;
  logic [1:0]  dmi_resp_resp;
  logic [31:0] dmi_resp_data;
  logic        reg_req;
  logic        reg_we;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_gnt = 1'b0;
  logic        reg_rvalid = 1'b0;
  logic [31:0] reg_rdata = 32'hBAD0BAD0;
  logic        reg_err = 1'b1;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int          op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    int          gnt_dly;   // ISSUE cycles before gnt; -1 = never granted
    int          rv_dly;    // cycles from gnt to rvalid; 0 = same cycle
    logic [31:0] rdata;
    logic        err;
    int          exp_resp;
    logic [31:0] exp_data;
    int          exp_req;   // cycles reg_req is expected high
  } vec_t;
  vec_t vecs[11];

  dmi_reg_bridge #(.ADDR_W(7), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_op(dmi_req_op), .dmi_req_data(dmi_req_data),
    .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
    .dmi_resp_resp(dmi_resp_resp), .dmi_resp_data(dmi_resp_data),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_gnt(reg_gnt), .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata), .reg_err(reg_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare each response on the cycle its handshake completes.
  always @(negedge clk) begin
    if (dmi_resp_valid && dmi_resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_code", 32'(dmi_resp_resp), 32'(e.resp));
        chk("resp_data", dmi_resp_data, e.data);
      end
    end
  end

  // Count cycles with reg_req high.
  always @(negedge clk) begin
    if (reg_req) req_cycles++;
  end

  task automatic drive_rv(input logic [31:0] rdata, input logic err);
    reg_rvalid = 1'b1;
    reg_rdata  = rdata;
    reg_err    = err;
  endtask

  task automatic clear_bus();
    reg_gnt    = 1'b0;
    reg_rvalid = 1'b0;
    reg_rdata  = 32'hBAD0BAD0;
    reg_err    = 1'b1;
  endtask

  // Present a request until accepted; optionally queue its expected response.
  task automatic issue(input int op, input logic [6:0] addr, input logic [31:0] data,
                       input int er, input logic [31:0] ed, input bit push);
    int k;
    k = 0;
    dmi_req_valid = 1'b1;
    dmi_req_op    = 2'(op);
    dmi_req_addr  = addr;
    dmi_req_data  = data;
    while (!dmi_req_ready && k < 40) begin
      tick();
      k++;
    end
    if (!dmi_req_ready) begin
      chk("req_accept_timeout", 32'd0, 32'd1);
    end else begin
      if (push) exp_q.push_back('{resp: 2'(er), data: ed});
      tick();
    end
    dmi_req_valid = 1'b0;
  endtask

  // Play the register-bus side of one access, starting in the first ISSUE cycle.
  task automatic serve(input vec_t v);
    int k;
    if (v.op == OP_READ || v.op == OP_WRITE) begin
      chk("reg_addr", 32'(reg_addr), 32'(v.addr));
      chk("reg_we", 32'(reg_we), (v.op == OP_WRITE) ? 32'd1 : 32'd0);
      chk("reg_wdata", reg_wdata, v.wdata);
      if (v.gnt_dly < 0) begin
        k = 0;
        while (reg_req && k < 40) begin
          tick();
          k++;
        end
      end else begin
        for (int i = 0; i < v.gnt_dly; i++) tick();
        chk("reg_addr_at_gnt", 32'(reg_addr), 32'(v.addr));
        reg_gnt = 1'b1;
        if (v.rv_dly == 0) drive_rv(v.rdata, v.err);
        tick();
        clear_bus();
        if (v.rv_dly > 0) begin
          for (int j = 1; j < v.rv_dly; j++) tick();
          drive_rv(v.rdata, v.err);
          tick();
          clear_bus();
        end
      end
    end
  endtask

  // Wait (bounded) until every queued response has been compared.
  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{OP_NOP,   7'h10, 32'h0,      0, 0, 32'h0,      1'b0, RS_OK,   32'h0,        0};
    vecs[1]  = '{OP_READ,  7'h11, 32'h0,      3, 2, 32'hDEADBEEF, 1'b0, RS_OK, 32'hDEADBEEF, 4};
    vecs[2]  = '{OP_WRITE, 7'h04, 32'h1,      0, 0, 32'h55555555, 1'b1, RS_FAIL, 32'h0,      1};
    vecs[3]  = '{OP_RSVD,  7'h05, 32'h0,      0, 0, 32'h0,      1'b0, RS_FAIL, 32'h0,        0};
    vecs[4]  = '{OP_READ,  7'h20, 32'h0,      0, 0, 32'h12345678, 1'b0, RS_OK, 32'h12345678, 1};
    vecs[5]  = '{OP_READ,  7'h21, 32'h0,      1, 1, 32'h0000FFFF, 1'b1, RS_FAIL, 32'h0,      2};
    vecs[6]  = '{OP_WRITE, 7'h7F, 32'hA5A5A5A5, 2, 3, 32'h77777777, 1'b0, RS_OK, 32'h0,      3};
    vecs[7]  = '{OP_READ,  7'h30, 32'h0,     -1, 0, 32'h0,      1'b0, RS_FAIL, 32'h0,        8};
    vecs[8]  = '{OP_READ,  7'h31, 32'h0,      7, 0, 32'h0BADF00D, 1'b0, RS_OK, 32'h0BADF00D, 8};
    vecs[9]  = '{OP_READ,  7'h32, 32'h0,      2, 5, 32'hC0FFEE00, 1'b0, RS_OK, 32'hC0FFEE00, 3};
    vecs[10] = '{OP_READ,  7'h33, 32'h0,      2, 6, 32'hC0FFEE01, 1'b0, RS_FAIL, 32'h0,      3};

    // Reset values.
    tick();
    tick();
    chk("rst_req_ready", 32'(dmi_req_ready), 32'd0);
    chk("rst_resp_valid", 32'(dmi_resp_valid), 32'd0);
    chk("rst_resp_resp", 32'(dmi_resp_resp), 32'd0);
    chk("rst_resp_data", dmi_resp_data, 32'd0);
    chk("rst_reg_req", 32'(reg_req), 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_reg_wdata", reg_wdata, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_req_ready", 32'(dmi_req_ready), 32'd1);

    // Table-driven transactions.
    for (int n = 0; n < 11; n++) begin
      req_cycles = 0;
      issue(vecs[n].op, vecs[n].addr, vecs[n].wdata, vecs[n].exp_resp, vecs[n].exp_data, 1'b1);
      if (vecs[n].op == OP_NOP || vecs[n].op == OP_RSVD)
        chk("short_op_latency", 32'(dmi_resp_valid), 32'd1);
      serve(vecs[n]);
      drain();
      chk("reg_req_cycles", 32'(req_cycles), 32'(vecs[n].exp_req));
      tick();
    end

    // Minimum READ latency with response backpressure and a pending request.
    dmi_resp_ready = 1'b0;
    issue(OP_READ, 7'h12, 32'h0, RS_OK, 32'hCAFEF00D, 1'b1);
    chk("read_req_n1", 32'(reg_req), 32'd1);
    chk("read_resp_valid_n1", 32'(dmi_resp_valid), 32'd0);
    reg_gnt = 1'b1;
    drive_rv(32'hCAFEF00D, 1'b0);
    tick();
    clear_bus();
    chk("read_resp_valid_n2", 32'(dmi_resp_valid), 32'd1);
    dmi_req_valid = 1'b1;
    dmi_req_op    = 2'(OP_NOP);
    dmi_req_addr  = 7'h13;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_resp_valid", 32'(dmi_resp_valid), 32'd1);
      chk("bp_resp_resp", 32'(dmi_resp_resp), 32'(RS_OK));
      chk("bp_resp_data", dmi_resp_data, 32'hCAFEF00D);
      chk("bp_req_ready", 32'(dmi_req_ready), 32'd0);
    end
    dmi_resp_ready = 1'b1;
    tick();
    chk("after_hs_resp_valid", 32'(dmi_resp_valid), 32'd0);
    chk("after_hs_req_ready", 32'(dmi_req_ready), 32'd1);
    exp_q.push_back('{resp: 2'(RS_OK), data: 32'h0});
    tick();
    dmi_req_valid = 1'b0;
    chk("pending_nop_resp_valid", 32'(dmi_resp_valid), 32'd1);
    drain();
    tick();

    // Timeout held under backpressure; late gnt/rvalid must not alter it.
    dmi_resp_ready = 1'b0;
    issue(OP_READ, 7'h34, 32'h0, RS_FAIL, 32'h0, 1'b1);
    for (int i = 0; i < 40 && reg_req; i++) tick();
    chk("tmo_resp_valid", 32'(dmi_resp_valid), 32'd1);
    reg_gnt = 1'b1;
    drive_rv(32'h11111111, 1'b0);
    tick();
    tick();
    clear_bus();
    chk("late_rv_resp", 32'(dmi_resp_resp), 32'(RS_FAIL));
    chk("late_rv_data", dmi_resp_data, 32'h0);
    dmi_resp_ready = 1'b1;
    drain();
    tick();
    issue(OP_NOP, 7'h10, 32'h0, RS_OK, 32'h0, 1'b1);
    drain();
    tick();

    // Reset while waiting for rvalid: transaction abandoned, no response.
    issue(OP_READ, 7'h40, 32'h0, RS_OK, 32'h0, 1'b0);
    reg_gnt = 1'b1;
    tick();
    clear_bus();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_reg_req", 32'(reg_req), 32'd0);
    chk("mid_rst_resp_valid", 32'(dmi_resp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(dmi_req_ready), 32'd0);
    chk("mid_rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("mid_rst_resp_data", dmi_resp_data, 32'd0);
    reset = 1'b0;
    drive_rv(32'h22222222, 1'b0);
    tick();
    clear_bus();
    chk("post_mid_rst_req_ready", 32'(dmi_req_ready), 32'd1);
    tick();
    tick();
    chk("no_resp_after_rst", 32'(dmi_resp_valid), 32'd0);
    issue(OP_RSVD, 7'h01, 32'h0, RS_FAIL, 32'h0, 1'b1);
    drain();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
